// File: rtl/instr_fetch_client_if.sv
// Fetch-client bus: combinational ROM lookup plus the decoder-facing valid/ready stream.
// master = fetch client, slave = ROM/decoder side.
interface instr_fetch_client_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output mem_address,
    input  mem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  mem_address,
    output mem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/instr_fetch_client.sv
// Instruction fetch requester: PC sequencing against a combinational ROM,
// with a small {pc, instr} FIFO feeding the decoder.
//
//  state   | meaning
//  S_IDLE  | waiting for start, no fetches
//  S_FETCH | fetching one word per cycle while the FIFO has room
//  S_DRAIN | fetching stopped, emptying the FIFO before returning idle
module instr_fetch_client #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_pc,
  input  logic              i_stop,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_fetch_count,
  instr_fetch_client_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [PTR_W:0]    w_count_nxt;
  logic [CNT_W-1:0]  r_fetch_count;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
      S_FETCH: if (i_stop) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A flushing redirect swallows any same-cycle pop along with the rest of the FIFO.
  always_comb begin
    w_pop   = (r_count != '0) && bus.out_ready;
    w_push  = 1'b0;
    w_flush = 1'b0;
    o_busy  = (r_state != S_IDLE);
    if (r_state == S_FETCH && !i_stop) begin
      if (i_redirect_valid)                  w_flush = 1'b1;
      else if (r_count < FULL_CNT || w_pop)  w_push  = 1'b1;
    end
  end

  always_comb begin
    if (w_flush) w_count_nxt = '0;
    else         w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_fetch_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_pc[r_wr_ptr]    <= r_pc;
          r_mem_instr[r_wr_ptr] <= bus.mem_data;
          r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (r_state == S_IDLE && i_start) r_pc <= i_start_pc;
      else if (w_flush)                 r_pc <= i_redirect_pc;
      else if (w_push)                  r_pc <= r_pc + ADDR_W'(1);
      if (w_push && r_fetch_count != '1) r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign bus.mem_address = r_pc;
  assign bus.out_valid   = (r_count != '0);
  assign bus.out_instr   = r_mem_instr[r_rd_ptr];
  assign bus.out_pc      = r_mem_pc[r_rd_ptr];
  assign o_fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_client.sv
// Directed bench for instr_fetch_client: expected PCs are queued as stimulus
// is issued and a negedge monitor checks every delivered word against them.
module tb_instr_fetch_client;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        redir = 1'b0;
  logic [2:0]  start_pc = '0;
  logic [2:0]  redir_pc = '0;
  logic        busy;
  logic [15:0] fcnt;
  int          errors = 0;
  int          checks = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  mon_p;

  instr_fetch_client_if bus();

  instr_fetch_client dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_start_pc       (start_pc),
    .i_stop           (stop),
    .i_redirect_valid (redir),
    .i_redirect_pc    (redir_pc),
    .o_busy           (busy),
    .o_fetch_count    (fcnt),
    .bus              (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = 32'hA000_0000 | {29'd0, bus.mem_address};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; redir = 1'b0; bus.out_ready = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [2:0] pc);
    start_pc = pc; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic expect_pc(input logic [2:0] p);
    exp_q.push_back(p);
  endtask

  // A handshake during a flushing redirect delivers nothing.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready && !(redir && !stop)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %0d expected none", bus.out_pc);
        end else begin
          mon_p = exp_q.pop_front();
          chk("pop_pc", {29'd0, bus.out_pc}, {29'd0, mon_p});
          chk("pop_instr", bus.out_instr, 32'hA000_0000 | {29'd0, mon_p});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] p;
    bus.out_ready = 1'b0;
    tick(1);

    // 1: reset state, then free-running fetch with PC wrap
    do_reset();
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", {29'd0, bus.mem_address}, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_pc", {29'd0, bus.out_pc}, 0);
    chk("rst_fcnt", {16'd0, fcnt}, 0);
    bus.out_ready = 1'b1;
    do_start(3'd0);
    chk("t1_addr0", {29'd0, bus.mem_address}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    p = 3'd0;
    for (int i = 0; i < 9; i++) begin
      expect_pc(p);
      p = p + 3'd1;
    end
    tick(9);
    do_stop();
    tick(2);
    chk("t1_idle", {31'd0, busy}, 0);
    chk("t1_fcnt", {16'd0, fcnt}, 9);
    chk("t1_qempty", exp_q.size(), 0);

    // 2: backpressure fills the FIFO, then release
    do_reset();
    do_start(3'd5);
    tick(4);
    chk("t2_addr", {29'd0, bus.mem_address}, 7);
    chk("t2_fcnt", {16'd0, fcnt}, 2);
    chk("t2_valid", {31'd0, bus.out_valid}, 1);
    chk("t2_hold_pc", {29'd0, bus.out_pc}, 5);
    chk("t2_hold_instr", bus.out_instr, 32'hA000_0005);
    expect_pc(3'd5); expect_pc(3'd6); expect_pc(3'd7); expect_pc(3'd0);
    bus.out_ready = 1'b1;
    tick(2);
    do_stop();
    tick(2);
    chk("t2_idle", {31'd0, busy}, 0);
    chk("t2_fcnt_end", {16'd0, fcnt}, 4);
    chk("t2_qempty", exp_q.size(), 0);

    // 3: redirect on a full FIFO discards buffered words
    do_reset();
    do_start(3'd1);
    tick(3);
    redir = 1'b1; redir_pc = 3'd4; bus.out_ready = 1'b1;
    tick(1);
    redir = 1'b0;
    chk("t3_flushed", {31'd0, bus.out_valid}, 0);
    chk("t3_addr", {29'd0, bus.mem_address}, 4);
    expect_pc(3'd4); expect_pc(3'd5);
    tick(2);
    do_stop();
    tick(2);
    chk("t3_idle", {31'd0, busy}, 0);
    chk("t3_fcnt", {16'd0, fcnt}, 4);
    chk("t3_qempty", exp_q.size(), 0);

    // 4: stop with two buffered entries drains them before idling
    do_reset();
    do_start(3'd0);
    tick(3);
    do_stop();
    chk("t4_busy_a", {31'd0, busy}, 1);
    chk("t4_valid_a", {31'd0, bus.out_valid}, 1);
    expect_pc(3'd0); expect_pc(3'd1);
    bus.out_ready = 1'b1;
    tick(1);
    chk("t4_busy_b", {31'd0, busy}, 1);
    tick(1);
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_empty", {31'd0, bus.out_valid}, 0);
    tick(3);
    chk("t4_fcnt", {16'd0, fcnt}, 2);
    chk("t4_addr", {29'd0, bus.mem_address}, 2);
    chk("t4_qempty", exp_q.size(), 0);

    // 5: stop and redirect together -> stop wins, FIFO and PC kept
    do_reset();
    do_start(3'd3);
    tick(3);
    stop = 1'b1; redir = 1'b1; redir_pc = 3'd0;
    tick(1);
    stop = 1'b0; redir = 1'b0;
    chk("t5_busy", {31'd0, busy}, 1);
    chk("t5_addr", {29'd0, bus.mem_address}, 5);
    chk("t5_valid", {31'd0, bus.out_valid}, 1);
    chk("t5_head", {29'd0, bus.out_pc}, 3);
    expect_pc(3'd3); expect_pc(3'd4);
    bus.out_ready = 1'b1;
    tick(3);
    chk("t5_idle", {31'd0, busy}, 0);
    chk("t5_qempty", exp_q.size(), 0);

    // 6: reset mid-fetch with a full FIFO, then restart
    do_reset();
    do_start(3'd2);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t6_valid", {31'd0, bus.out_valid}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_fcnt", {16'd0, fcnt}, 0);
    chk("t6_addr", {29'd0, bus.mem_address}, 0);
    chk("t6_instr", bus.out_instr, 0);
    bus.out_ready = 1'b1;
    do_start(3'd6);
    expect_pc(3'd6); expect_pc(3'd7);
    tick(2);
    do_stop();
    tick(2);
    chk("t6_idle", {31'd0, busy}, 0);
    chk("t6_fcnt_end", {16'd0, fcnt}, 2);
    chk("t6_qempty", exp_q.size(), 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
